conv_col_stream: RTL

CONV_COL_STREAM -- requirements
Module: conv_col_stream

---
 rtl/conv_col_stream.sv | 129 ++++++++++++
 1 files changed

// File: rtl/conv_col_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : conv_col_stream
//  Brief    : Streaming KxK convolution fed one image column per beat, with
//             shift / ReLU / saturation post-processing and a 1-deep output.
//  Revision : 1.0  initial release
// ============================================================================
module conv_col_stream #(
    parameter int DW    = 8,
    parameter int K     = 3,
    parameter int CW    = 4,
    parameter int OW    = 16,
    parameter int SHIFT = 0,
    parameter int RELU  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [K*DW-1:0]      in_col,
    input  logic                 in_first,
    input  logic                 coef_we,
    input  logic [5:0]           coef_addr,
    input  logic [CW-1:0]        coef_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_pix
);

    localparam int AW = DW + CW + $clog2(K*K) + 1;
    localparam int NW = $clog2(K+1);
    localparam logic [NW-1:0] c_k = NW'(K);

    logic signed [CW-1:0] r_coef [K*K];
    logic signed [AW-1:0] r_psum [K];
    logic [NW-1:0]        r_cnt;

    logic                 w_accept;
    logic                 w_produce;
    logic [NW-1:0]        w_cnt_nxt;
    logic signed [AW-1:0] w_dot      [K];
    logic signed [AW-1:0] w_psum_nxt [K];
    logic signed [AW-1:0] w_shifted;
    logic signed [AW-1:0] w_relu;
    logic signed [OW-1:0] w_sat;

    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Per-column dot products: unsigned pixels against signed coefficients.
    always_comb begin
        for (int c = 0; c < K; c++) begin
            w_dot[c] = '0;
            for (int r = 0; r < K; r++) begin
                w_dot[c] = w_dot[c]
                         + $signed({{(AW-DW){1'b0}}, in_col[r*DW +: DW]})
                         * $signed({{(AW-CW){r_coef[r*K+c][CW-1]}}, r_coef[r*K+c]});
            end
        end
    end

    // A row start drops the carried partial sums so old-row columns never leak in.
    always_comb begin
        w_psum_nxt[0] = w_dot[0];
        for (int c = 1; c < K; c++) begin
            w_psum_nxt[c] = in_first ? w_dot[c] : w_dot[c] + r_psum[c-1];
        end
    end

    assign w_cnt_nxt = in_first       ? NW'(1) :
                       (r_cnt == c_k) ? c_k    : r_cnt + 1'b1;
    assign w_produce = w_accept && (w_cnt_nxt == c_k);

    assign w_shifted = w_psum_nxt[K-1] >>> SHIFT;
    assign w_relu    = ((RELU != 0) && w_shifted[AW-1]) ? '0 : w_shifted;

    generate
        if (AW > OW) begin : g_sat
            localparam logic signed [AW-1:0] c_max = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
            localparam logic signed [AW-1:0] c_min = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
            always_comb begin
                if (w_relu > c_max) begin
                    w_sat = c_max[OW-1:0];
                end else if (w_relu < c_min) begin
                    w_sat = c_min[OW-1:0];
                end else begin
                    w_sat = w_relu[OW-1:0];
                end
            end
        end else begin : g_ext
            assign w_sat = OW'(w_relu);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K*K; i++) begin
                r_coef[i] <= '0;
            end
            for (int c = 0; c < K; c++) begin
                r_psum[c] <= '0;
            end
            r_cnt     <= '0;
            out_valid <= 1'b0;
            out_pix   <= '0;
        end else begin
            for (int i = 0; i < K*K; i++) begin
                if (coef_we && (coef_addr == 6'(i))) begin
                    r_coef[i] <= coef_data;
                end
            end
            if (w_accept) begin
                for (int c = 0; c < K; c++) begin
                    r_psum[c] <= w_psum_nxt[c];
                end
                r_cnt <= w_cnt_nxt;
            end
            if (w_produce) begin
                out_valid <= 1'b1;
                out_pix   <= w_sat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
